// File: rtl/systolic_result_reader.sv
// systolic_result_reader: drain side of the 2x2 systolic array.
// A start pulse arms a latency counter. When the counter expires, the four
// signed products are captured into one entry of a two-deep ping-pong buffer.
// Captured jobs are then streamed out as four tagged beats over valid/ready.
module systolic_result_reader #(
    parameter int DATA_W  = 17,
    parameter int LATENCY = 7,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              overflow,
    input  logic              clr_ovf
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               full_q, full_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               idx_q, idx_d;
    logic                     ovf_q, ovf_d;
    logic signed [DATA_W-1:0] mem_q [2][4];
    logic signed [DATA_W-1:0] mem_d [2][4];

    logic hs;
    logic free_evt;
    logic cap_evt;
    logic tgt_free;
    logic cap_ok;
    logic drop;

    // Output view of the entry at the read pointer; data is forced to zero when nothing is held.
    always_comb begin
        out_valid = full_q[rd_ptr_q];
        out_data  = out_valid ? mem_q[rd_ptr_q][idx_q] : '0;
        out_idx   = idx_q;
        out_last  = out_valid && (idx_q == 2'd3);
        busy      = (state_q == S_WAIT);
        overflow  = ovf_q;
    end

    // Handshake, capture and drop events. A full target entry still accepts the
    // capture when the last beat of that same entry is handed off on this edge.
    always_comb begin
        hs       = out_valid && out_ready;
        free_evt = hs && (idx_q == 2'd3);
        cap_evt  = (state_q == S_WAIT) && (cnt_q == CNT_W'(LATENCY));
        tgt_free = !full_q[wr_ptr_q] || (free_evt && (rd_ptr_q == wr_ptr_q));
        cap_ok   = cap_evt && tgt_free;
        drop     = cap_evt && !tgt_free;
    end

    // Next-state for the capture FSM, the buffer bookkeeping and the drain index.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;

        // A start always (re)arms the counter, even on the capture edge itself.
        if (start) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
        end else if (state_q == S_WAIT) begin
            if (cap_evt) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Freeing is applied before filling so a same-edge free and refill leaves the entry full.
        if (hs) begin
            if (idx_q == 2'd3) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
                idx_d            = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        if (cap_ok) begin
            mem_d[wr_ptr_q][0] = c11;
            mem_d[wr_ptr_q][1] = c12;
            mem_d[wr_ptr_q][2] = c21;
            mem_d[wr_ptr_q][3] = c22;
            full_d[wr_ptr_q]   = 1'b1;
            wr_ptr_d           = ~wr_ptr_q;
        end

        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
        end
    end

    // Result storage; contents only matter once the matching full bit is set.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_systolic_result_reader.sv
// Self-checking bench for systolic_result_reader.
// The reference model is a job queue (at most two jobs) plus a countdown to the
// next capture. Directed scenarios are followed by a randomized run.
module tb_systolic_result_reader;

    localparam int DATA_W = 17;
    localparam int LAT    = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] c11, c12, c21, c22;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_idx;
    logic              out_last;
    logic              busy;
    logic              overflow;
    logic              clr_ovf;

    systolic_result_reader #(.DATA_W(DATA_W), .LATENCY(LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    logic [4*DATA_W-1:0] mq [$];
    int                  m_beat;
    bit                  m_pend;
    int                  m_left;
    bit                  m_ovf;

    // Beats accepted from the DUT, used by the directed checks.
    logic [DATA_W-1:0]   acc_log [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_beat = 0;
        m_pend = 0;
        m_left = 0;
        m_ovf  = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held at that edge.
    task automatic model_step();
        bit cap;
        bit drop;
        cap  = 0;
        drop = 0;
        if (m_pend) begin
            m_left--;
            cap = (m_left == 0);
        end
        if (mq.size() > 0 && out_ready) begin
            if (m_beat == 3) begin
                void'(mq.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (cap) begin
            if (mq.size() < 2) mq.push_back({c22, c21, c12, c11});
            else drop = 1;
        end
        if (start) begin
            m_pend = 1;
            m_left = LAT;
        end else if (cap) begin
            m_pend = 0;
        end
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    task automatic model_check();
        bit v;
        v = (mq.size() > 0);
        chk("valid", out_valid, v);
        if (v) begin
            chk("data", out_data, mq[0][m_beat*DATA_W +: DATA_W]);
            chk("idx", out_idx, m_beat);
            chk("last", out_last, (m_beat == 3));
        end
        chk("busy", busy, m_pend);
        chk("overflow", overflow, m_ovf);
    endtask

    // One cycle: inputs applied now (just after a falling edge), checked at the next falling edge.
    task automatic cyc(input bit s, input bit rdy, input bit clr);
        start     = s;
        out_ready = rdy;
        clr_ovf   = clr;
        if (out_valid && rdy) acc_log.push_back(out_data);
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, rdy, 0);
    endtask

    task automatic set_c(input logic [DATA_W-1:0] a, b, c, d);
        c11 = a; c12 = b; c21 = c; c22 = d;
    endtask

    initial begin
        rst = 1'b1;
        start = 0; out_ready = 0; clr_ovf = 0;
        set_c(0, 0, 0, 0);
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single job, consumer always ready.
        set_c(19, 22, 43, 50);
        acc_log.delete();
        cyc(1, 1, 0);
        idle(6, 1);
        chk("single_busy_before_cap", busy, 1);
        idle(1, 1);
        chk("single_first_valid", out_valid, 1);
        idle(5, 1);
        chk("single_len", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("single_b0", acc_log[0], 19);
            chk("single_b1", acc_log[1], 22);
            chk("single_b2", acc_log[2], 43);
            chk("single_b3", acc_log[3], 50);
        end

        // Backpressure on beat idx 1.
        acc_log.delete();
        cyc(1, 0, 0);
        idle(7, 0);
        cyc(0, 1, 0);
        idle(3, 0);
        chk("bp_hold_idx", out_idx, 1);
        chk("bp_hold_data", out_data, 22);
        idle(4, 1);
        chk("bp_len", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("bp_b2", acc_log[2], 43);
            chk("bp_b3", acc_log[3], 50);
        end

        // Negative and extreme values pass through bit-exact.
        set_c(17'h08000, 17'h18000, 17'h1FFFF, 17'h00000);
        acc_log.delete();
        cyc(1, 1, 0);
        idle(12, 1);
        chk("ext_len", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("ext_b0", acc_log[0], 17'h08000);
            chk("ext_b1", acc_log[1], 17'h18000);
            chk("ext_b2", acc_log[2], 17'h1FFFF);
            chk("ext_b3", acc_log[3], 17'h00000);
        end

        // Ping-pong fill and overflow on the third capture.
        for (int j = 1; j <= 3; j++) begin
            set_c(17'(j), 17'(10 + j), 17'(20 + j), 17'(30 + j));
            cyc(1, 0, 0);
            idle(7, 0);
        end
        chk("ovf_set", overflow, 1);
        acc_log.delete();
        idle(12, 1);
        chk("pp_len", acc_log.size(), 8);
        if (acc_log.size() == 8) begin
            chk("pp_job1", acc_log[0], 1);
            chk("pp_job2", acc_log[4], 2);
        end

        // Restart: second start abandons the first job.
        set_c(5, 6, 7, 8);
        cyc(1, 0, 0);
        idle(3, 0);
        cyc(1, 0, 0);
        idle(3, 0);
        chk("restart_no_early_cap", out_valid, 0);
        idle(4, 0);
        chk("restart_cap", out_valid, 1);

        // Asynchronous reset in the middle of draining, with overflow still set.
        idle(2, 1);
        chk("pre_rst_idx", out_idx, 2);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", out_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_idx", out_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        set_c(100, 101, 102, 103);
        acc_log.delete();
        cyc(1, 1, 0);
        idle(12, 1);
        chk("post_rst_len", acc_log.size(), 4);
        if (acc_log.size() == 4) chk("post_rst_b0", acc_log[0], 100);

        // Overflow again, then clear it.
        for (int j = 0; j < 3; j++) begin
            cyc(1, 0, 0);
            idle(7, 0);
        end
        chk("ovf_set2", overflow, 1);
        cyc(0, 0, 1);
        chk("ovf_clr", overflow, 0);
        idle(10, 1);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            set_c(17'($urandom), 17'($urandom), 17'($urandom), 17'($urandom));
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_result_reader.md
Name: systolic_result_reader

Overview:
- Drain side of the 2x2 systolic array. Captures the four 17-bit signed products c11, c12, c21, c22 a fixed number of cycles after a job starts.
- Buffers up to two completed jobs in a ping-pong buffer.
- Streams each job out as four beats over a valid/ready interface, tagged with an element index and a last flag.
- Lets the array begin a new job while the previous result is still draining.

Parameters:
- DATA_W, 17, width of each result element; matches the array's c outputs.
- LATENCY, 7, clock edges from the sampled start to the capture edge; equals the array counter span after rst release.
- CNT_W, 3, width of the latency counter; must satisfy 2^CNT_W > LATENCY.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse, driven in the same cycle the array's job begins.
- c11  input  DATA_W  array result row1 col1, signed.
- c12  input  DATA_W  array result row1 col2, signed.
- c21  input  DATA_W  array result row2 col1, signed.
- c22  input  DATA_W  array result row2 col2, signed.
- out_valid  output  1  out_data / out_idx / out_last are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  DATA_W  current result element, signed.
- out_idx  output  2  element tag: 0=c11, 1=c12, 2=c21, 3=c22.
- out_last  output  1  high on the idx 3 beat.
- busy  output  1  capture FSM is in WAIT.
- overflow  output  1  sticky; a capture was dropped because both buffers were full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst low, asynchronous): capture FSM to IDLE, counter 0, both buffer entries empty, read pointer 0, write pointer 0, beat index 0, overflow 0. All outputs 0.
- Capture FSM states are IDLE and WAIT.
  - IDLE -> WAIT on an edge with start=1; counter is loaded with 1.
  - In WAIT the counter increments each edge.
  - On the edge where counter==LATENCY, c11..c22 are registered into the entry at the write pointer, that entry is marked full, the write pointer toggles, and the FSM returns to IDLE.
  - A start sampled at edge k therefore produces a capture at edge k+LATENCY.
  - start=1 while in WAIT reloads the counter to 1 and abandons the pending job; no capture and no flag.
  - start=1 on the capture edge itself: the capture completes, then the FSM enters WAIT with counter=1.
- Buffer full at capture time:
  - If the target entry is full and is not freed on that same edge, the capture is dropped, overflow is set, and the write pointer is unchanged.
  - If the target entry is freed on the same edge (idx 3 handshake), the capture succeeds.
- Drain side:
  - out_valid = entry at the read pointer is full.
  - out_data = element out_idx of that entry; out_last = out_valid and out_idx==3.
  - Registered path: the first beat is visible in the cycle after the capture edge.
  - A handshake (out_valid and out_ready) advances out_idx.
  - The handshake on idx 3 marks the entry empty, toggles the read pointer, and resets out_idx to 0.
  - While out_ready is low, out_data, out_idx and out_last hold stable and out_valid stays high (AXI-style; no retraction).
  - Back-to-back jobs stream without a bubble: after the idx 3 beat of job N, job N+1's idx 0 beat appears in the next cycle if that entry is full.
- Width: data is passed through unmodified, with no sign extension or truncation.
- overflow: clr_ovf=1 clears it; if a drop occurs on the same edge, set wins.
- busy = (state==WAIT).

Test Plan:
- Single job: start pulse at edge 0; c = 19, 22, 43, 50; out_ready=1. Expect capture at edge 7; beats 19/0, 22/1, 43/2, 50/3 on four consecutive cycles; out_last only on 50; busy high on edges 1..6.
- Backpressure: same job with out_ready low for 3 cycles during beat idx 1. Expect out_data=22 and out_idx=1 held, out_valid held high; the stream resumes with 43 and 50.
- Negative and extreme values: c = 32768, -32768, -1, 0 (17-bit 0x08000, 0x18000, 0x1FFFF, 0x00000). Expect the bit-exact values on out_data.
- Ping-pong and overflow: out_ready=0, three jobs started 8 cycles apart with c11 = 1, 2, 3. Expect overflow set at the third capture. With out_ready then raised, expect exactly 8 beats, c11 values 1 then 2. clr_ovf clears the flag.
- Restart: start at edge 0 and again at edge 4. Expect a single capture at edge 11 and no capture at edge 7.
- Async reset mid-drain: rst low during beat idx 2. Expect out_valid=0 and overflow=0 immediately without a clock edge; the next job starts its output from idx 0.
